bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 100 ++++++++++
 tb/tb_bus_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (CPU/DMA) round-robin bus arbiter with wait-state hold,
// slave stall support and timeout abort.
module bus_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic        M0_AS_L,
    input  logic        M1_AS_L,
    input  logic        M0_WE_L,
    input  logic        M1_WE_L,
    input  logic [31:0] M0_Address,
    input  logic [31:0] M1_Address,
    input  logic [3:0]  M0_ByteEnable,
    input  logic [3:0]  M1_ByteEnable,
    input  logic [31:0] M0_DataOut,
    input  logic [31:0] M1_DataOut,
    output logic        M0_DTAck,
    output logic        M1_DTAck,
    output logic        M0_BusError,
    output logic        M1_BusError,
    output logic        Bus_AS_L,
    output logic        Bus_WE_L,
    output logic [31:0] Bus_Address,
    output logic [3:0]  Bus_ByteEnable,
    output logic [31:0] Bus_DataOut,
    input  logic        Bus_Wait_H,
    output logic [1:0]  Owner
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] XFER    = 3'd1;
    localparam logic [2:0] DONE    = 3'd2;
    localparam logic [2:0] ERR     = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;
    localparam logic [7:0] WS      = 8'(WAIT_STATES);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       grant1, busy, own_as_l;

    // last_q = 1 means M1 was granted last, so M0 wins the next tie
    assign grant1   = ~M1_AS_L & (M0_AS_L | ~last_q);
    assign busy     = (state_q == XFER) | (state_q == DONE) | (state_q == ERR);
    assign own_as_l = owner_q[1] ? M1_AS_L : M0_AS_L;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (~M0_AS_L | ~M1_AS_L) begin
                state_d = XFER;
                owner_d = grant1 ? 2'b10 : 2'b01;
                last_d  = grant1;
                cnt_d   = 8'd0;
            end
            XFER: begin
                cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                state_d = (Bus_Wait_H && cnt_q == TO_LAST) ? ERR :
                          (!Bus_Wait_H && cnt_q >= WS) ? DONE : XFER;
            end
            DONE, ERR: state_d = RELEASE;
            RELEASE: if (own_as_l) begin
                state_d = IDLE;
                owner_d = 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
            owner_q <= 2'b00;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign Owner          = owner_q;
    assign M0_DTAck       = (state_q == DONE || state_q == ERR) & owner_q[0];
    assign M1_DTAck       = (state_q == DONE || state_q == ERR) & owner_q[1];
    assign M0_BusError    = (state_q == ERR) & owner_q[0];
    assign M1_BusError    = (state_q == ERR) & owner_q[1];
    assign Bus_AS_L       = busy ? own_as_l : 1'b1;
    assign Bus_WE_L       = busy ? (owner_q[1] ? M1_WE_L : M0_WE_L) : 1'b1;
    assign Bus_Address    = busy ? (owner_q[1] ? M1_Address : M0_Address) : 32'd0;
    assign Bus_ByteEnable = busy ? (owner_q[1] ? M1_ByteEnable : M0_ByteEnable) : 4'd0;
    assign Bus_DataOut    = busy ? (owner_q[1] ? M1_DataOut : M0_DataOut) : 32'd0;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed table-driven bench for bus_arbiter (WAIT_STATES=1, TIMEOUT=16).
module tb_bus_arbiter;
    localparam logic [31:0] A0 = 32'h1000_0040, A1 = 32'h2000_0080;
    localparam logic [31:0] D0 = 32'hA0A0_5555, D1 = 32'hB1B1_AAAA;
    localparam logic [3:0]  B0 = 4'h3, B1 = 4'hC;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        m0_as = 1'b1, m1_as = 1'b1, wt = 1'b0;
    logic        m0_ack, m1_ack, m0_err, m1_err, bus_as, bus_we;
    logic [31:0] bus_addr, bus_data;
    logic [3:0]  bus_be;
    logic [1:0]  owner;
    int          checks = 0, failures = 0;

    typedef struct packed {
        logic       m0;
        logic       m1;
        logic       wt;
        logic [1:0] own;
        logic       busy;
        logic [1:0] ack;
        logic [1:0] err;
    } vec_t;
    vec_t tbl[29];

    bus_arbiter #(.WAIT_STATES(1), .TIMEOUT(16)) dut (
        .Clock(clk), .Reset_L(rst_n),
        .M0_AS_L(m0_as), .M1_AS_L(m1_as), .M0_WE_L(1'b0), .M1_WE_L(1'b1),
        .M0_Address(A0), .M1_Address(A1), .M0_ByteEnable(B0), .M1_ByteEnable(B1),
        .M0_DataOut(D0), .M1_DataOut(D1),
        .M0_DTAck(m0_ack), .M1_DTAck(m1_ack), .M0_BusError(m0_err), .M1_BusError(m1_err),
        .Bus_AS_L(bus_as), .Bus_WE_L(bus_we), .Bus_Address(bus_addr),
        .Bus_ByteEnable(bus_be), .Bus_DataOut(bus_data), .Bus_Wait_H(wt), .Owner(owner)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic a0, a1, w, input logic [1:0] o, input logic b,
                               input logic [1:0] k, e);
        return '{m0: a0, m1: a1, wt: w, own: o, busy: b, ack: k, err: e};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // bus expectations follow from the expected owner and the inputs currently driven
    task automatic check_outs(input string tag, input logic [1:0] own, input logic busy,
                              input logic [1:0] ack, err);
        logic s1;
        s1 = own[1];
        chk({tag, " owner"}, 32'(owner), 32'(own));
        chk({tag, " dtack"}, 32'({m1_ack, m0_ack}), 32'(ack));
        chk({tag, " buserr"}, 32'({m1_err, m0_err}), 32'(err));
        chk({tag, " bus_ctl"}, 32'({bus_as, bus_we, bus_be}),
            32'(busy ? {s1 ? m1_as : m0_as, s1, s1 ? B1 : B0} : {1'b1, 1'b1, 4'h0}));
        chk({tag, " bus_addr"}, bus_addr, busy ? (s1 ? A1 : A0) : 32'd0);
        chk({tag, " bus_data"}, bus_data, busy ? (s1 ? D1 : D0) : 32'd0);
    endtask

    task automatic cycle(input string tag, input logic a0, a1, w, input logic [1:0] o,
                         input logic b, input logic [1:0] k, e);
        m0_as = a0;
        m1_as = a1;
        wt    = w;
        @(negedge clk);
        check_outs(tag, o, b, k, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // tie after reset: M0, then M1, then M0 again
        tbl[0]  = v(0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        tbl[1]  = v(0, 0, 0, 2'b01, 1, 2'b00, 2'b00);
        tbl[2]  = v(0, 0, 0, 2'b01, 1, 2'b00, 2'b00);
        tbl[3]  = v(1, 0, 0, 2'b01, 1, 2'b01, 2'b00);
        tbl[4]  = v(1, 0, 0, 2'b01, 0, 2'b00, 2'b00);
        tbl[5]  = v(0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        tbl[6]  = v(0, 0, 0, 2'b10, 1, 2'b00, 2'b00);
        tbl[7]  = v(0, 0, 0, 2'b10, 1, 2'b00, 2'b00);
        tbl[8]  = v(0, 1, 0, 2'b10, 1, 2'b10, 2'b00);
        tbl[9]  = v(0, 1, 0, 2'b10, 0, 2'b00, 2'b00);
        tbl[10] = v(0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        tbl[11] = v(0, 0, 0, 2'b01, 1, 2'b00, 2'b00);
        tbl[12] = v(0, 0, 0, 2'b01, 1, 2'b00, 2'b00);
        tbl[13] = v(1, 1, 0, 2'b01, 1, 2'b01, 2'b00);
        tbl[14] = v(1, 1, 0, 2'b01, 0, 2'b00, 2'b00);
        tbl[15] = v(1, 1, 0, 2'b00, 0, 2'b00, 2'b00);
        // single M0 request, RELEASE held until AS_L rises
        tbl[16] = v(0, 1, 0, 2'b00, 0, 2'b00, 2'b00);
        tbl[17] = v(0, 1, 0, 2'b01, 1, 2'b00, 2'b00);
        tbl[18] = v(0, 1, 0, 2'b01, 1, 2'b00, 2'b00);
        tbl[19] = v(0, 1, 0, 2'b01, 1, 2'b01, 2'b00);
        tbl[20] = v(0, 1, 0, 2'b01, 0, 2'b00, 2'b00);
        tbl[21] = v(1, 1, 0, 2'b01, 0, 2'b00, 2'b00);
        tbl[22] = v(1, 1, 0, 2'b00, 0, 2'b00, 2'b00);
        // owner drops AS_L during XFER: transfer still acknowledged
        tbl[23] = v(0, 1, 0, 2'b00, 0, 2'b00, 2'b00);
        tbl[24] = v(1, 1, 0, 2'b01, 1, 2'b00, 2'b00);
        tbl[25] = v(1, 1, 0, 2'b01, 1, 2'b00, 2'b00);
        tbl[26] = v(1, 1, 0, 2'b01, 1, 2'b01, 2'b00);
        tbl[27] = v(1, 1, 0, 2'b01, 0, 2'b00, 2'b00);
        tbl[28] = v(1, 1, 0, 2'b00, 0, 2'b00, 2'b00);

        m0_as = 1'b0;
        #3;
        check_outs("reset", 2'b00, 1'b0, 2'b00, 2'b00);
        m0_as = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 29; i++)
            cycle($sformatf("row%0d", i), tbl[i].m0, tbl[i].m1, tbl[i].wt,
                  tbl[i].own, tbl[i].busy, tbl[i].ack, tbl[i].err);

        cycle("stall_idle", 1, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++)
            cycle($sformatf("stall%0d", i), 1, 0, 1, 2'b10, 1, 2'b00, 2'b00);
        cycle("stall_fall", 1, 0, 0, 2'b10, 1, 2'b00, 2'b00);
        cycle("stall_done", 1, 1, 0, 2'b10, 1, 2'b10, 2'b00);
        cycle("stall_rel", 1, 1, 0, 2'b10, 0, 2'b00, 2'b00);
        cycle("stall_end", 1, 1, 0, 2'b00, 0, 2'b00, 2'b00);

        cycle("to_idle", 0, 1, 1, 2'b00, 0, 2'b00, 2'b00);
        for (int i = 0; i < 16; i++)
            cycle($sformatf("to_xfer%0d", i), 0, 1, 1, 2'b01, 1, 2'b00, 2'b00);
        cycle("to_err", 0, 1, 1, 2'b01, 1, 2'b01, 2'b01);
        cycle("to_hold", 0, 1, 1, 2'b01, 0, 2'b00, 2'b00);
        cycle("to_rel", 1, 1, 0, 2'b01, 0, 2'b00, 2'b00);
        cycle("to_end", 1, 1, 0, 2'b00, 0, 2'b00, 2'b00);

        cycle("rst_grant", 1, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        cycle("rst_xfer", 0, 0, 0, 2'b10, 1, 2'b00, 2'b00);
        @(negedge clk);
        check_outs("rst_pre", 2'b10, 1'b1, 2'b00, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", 2'b00, 1'b0, 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst_hold", 2'b00, 1'b0, 2'b00, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("post_x0", 0, 0, 0, 2'b01, 1, 2'b00, 2'b00);
        cycle("post_x1", 0, 0, 0, 2'b01, 1, 2'b00, 2'b00);
        cycle("post_done", 1, 0, 0, 2'b01, 1, 2'b01, 2'b00);
        cycle("post_rel", 1, 0, 0, 2'b01, 0, 2'b00, 2'b00);
        cycle("post_idle", 1, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        cycle("post_m1", 1, 0, 0, 2'b10, 1, 2'b00, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
